// File: rtl/os_psum_drain.sv
// rtl/os_psum_drain.sv - snapshot the output-stationary psum array and drain it one PE row per beat
module os_psum_drain #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           relu_en,
  input  logic [addr_bw-1:0]             base_addr,
  input  logic [row*col*psum_bw-1:0]     in_sta,
  output logic                           o_valid,
  input  logic                           o_ready,
  output logic [col*psum_bw-1:0]         o_data,
  output logic [addr_bw-1:0]             o_addr,
  output logic                           busy,
  output logic                           done,
  output logic                           start_dropped
);

  localparam int ROW_W = col * psum_bw;
  localparam int RW    = (row > 1) ? $clog2(row) : 1;

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t                       state_q;
  logic [RW-1:0]                row_idx_q;
  logic [row*col*psum_bw-1:0]   snap_q;
  logic                         relu_q;
  logic [addr_bw-1:0]           base_q;
  logic                         o_valid_q;
  logic [ROW_W-1:0]             o_data_q;
  logic [addr_bw-1:0]           o_addr_q;
  logic                         busy_q;
  logic                         done_q;
  logic                         dropped_q;

  logic [RW-1:0]                row_nxt_d;
  logic [addr_bw-1:0]           addr_nxt_d;

  // Selects one PE row and zeroes negative lanes when ReLU is enabled.
  function automatic logic [ROW_W-1:0] shape_row(input logic [row*col*psum_bw-1:0] arr,
                                                 input int idx, input logic en);
    logic [ROW_W-1:0] r;
    r = arr[idx*ROW_W +: ROW_W];
    for (int c = 0; c < col; c++) begin
      if (en && r[c*psum_bw + psum_bw - 1]) r[c*psum_bw +: psum_bw] = '0;
    end
    return r;
  endfunction

  assign row_nxt_d  = row_idx_q + RW'(1);
  assign addr_nxt_d = base_q + addr_bw'(row_nxt_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      row_idx_q <= '0;
      snap_q    <= '0;
      relu_q    <= 1'b0;
      base_q    <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_addr_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            snap_q    <= in_sta;
            relu_q    <= relu_en;
            base_q    <= base_addr;
            row_idx_q <= '0;
            o_valid_q <= 1'b1;
            o_data_q  <= shape_row(in_sta, 0, relu_en);
            o_addr_q  <= base_addr;
            busy_q    <= 1'b1;
            state_q   <= DRAIN;
          end
        end
        DRAIN: begin
          if (start) dropped_q <= 1'b1;
          if (o_ready) begin
            if (row_idx_q == RW'(row - 1)) begin
              o_valid_q <= 1'b0;
              o_data_q  <= '0;
              o_addr_q  <= '0;
              done_q    <= 1'b1;
              state_q   <= DONE;
            end else begin
              // Preload the next beat so outputs stay purely registered.
              row_idx_q <= row_nxt_d;
              o_data_q  <= shape_row(snap_q, int'(row_nxt_d), relu_q);
              o_addr_q  <= addr_nxt_d;
            end
          end
        end
        DONE: begin
          if (start) dropped_q <= 1'b1;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_valid       = o_valid_q;
  assign o_data        = o_data_q;
  assign o_addr        = o_addr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign start_dropped = dropped_q;

endmodule

// File: tb/tb_os_psum_drain.sv
// tb/tb_os_psum_drain.sv - randomized bench for os_psum_drain against a queue-based beat model
module tb_os_psum_drain;
  localparam int R  = 8;
  localparam int C  = 8;
  localparam int PW = 16;
  localparam int AW = 11;
  localparam int BW = C * PW;

  logic             clk = 1'b0;
  logic             reset, start, relu_en, o_ready;
  logic [AW-1:0]    base_addr;
  logic [R*C*PW-1:0] in_sta;
  logic             o_valid, busy, done, start_dropped;
  logic [BW-1:0]    o_data;
  logic [AW-1:0]    o_addr;

  always #5 clk = ~clk;

  os_psum_drain #(.row(R), .col(C), .psum_bw(PW), .addr_bw(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en), .base_addr(base_addr),
    .in_sta(in_sta), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_addr(o_addr),
    .busy(busy), .done(done), .start_dropped(start_dropped)
  );

  typedef struct {
    logic [BW-1:0] d;
    logic [AW-1:0] a;
  } beat_t;

  beat_t          exp_q[$];
  bit             m_done, m_drop;
  int             cyc = 0, start_cyc = 0;
  int             checks = 0, failures = 0;
  bit             chk_en = 0, rdy_mode = 0;
  logic [BW-1:0]  acc_d[$];
  logic [AW-1:0]  acc_a[$];
  int             acc_c[$];
  int             done_cnt = 0, done_cyc = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  // Reference: a start in an idle cycle queues all eight beats from the sampled array.
  always @(posedge clk) begin : model
    bit            busy_now;
    beat_t         b;
    logic [PW-1:0] v;
    if (reset) begin
      exp_q.delete();
      m_done = 0;
      m_drop = 0;
    end else begin
      busy_now = (exp_q.size() > 0) || m_done;
      m_done   = 0;
      if (start && busy_now) m_drop = 1;
      if (exp_q.size() > 0 && o_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) m_done = 1;
      end
      if (start && !busy_now) begin
        start_cyc = cyc;
        for (int r = 0; r < R; r++) begin
          for (int c = 0; c < C; c++) begin
            v = in_sta[(r*C + c)*PW +: PW];
            if (relu_en && v[PW-1]) v = '0;
            b.d[c*PW +: PW] = v;
          end
          b.a = base_addr + AW'(r);
          exp_q.push_back(b);
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin : compare
    bit exp_v;
    if (chk_en) begin
      exp_v = exp_q.size() > 0;
      check("o_valid", BW'(o_valid), BW'(exp_v));
      check("o_data", o_data, exp_v ? exp_q[0].d : '0);
      check("o_addr", BW'(o_addr), exp_v ? BW'(exp_q[0].a) : '0);
      check("done", BW'(done), BW'(m_done));
      check("busy", BW'(busy), BW'(exp_v || m_done));
      check("start_dropped", BW'(start_dropped), BW'(m_drop));
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    o_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!reset && o_valid && o_ready) begin
      acc_d.push_back(o_data);
      acc_a.push_back(o_addr);
      acc_c.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    acc_d.delete();
    acc_a.delete();
    acc_c.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start(input logic relu, input logic [AW-1:0] base);
    clear_logs();
    relu_en   = relu;
    base_addr = base;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_cnt == 0 && n < 200) begin
      step();
      n++;
    end
    check(name, BW'(n < 200), BW'(1));
    step();
  endtask

  task automatic rand_sta();
    for (int i = 0; i < R*C*PW/32; i++) in_sta[i*32 +: 32] = $urandom;
  endtask

  initial begin
    bit fired;
    int n;
    reset = 1'b1; start = 1'b0; relu_en = 1'b0; base_addr = '0; in_sta = '0; o_ready = 1'b1;
    step();
    chk_en = 1;
    step();
    check("reset_busy", BW'(busy), BW'(0));
    reset = 1'b0;
    step();

    // Basic drain with PE(r,c) = r*16+c.
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) in_sta[(r*C + c)*PW +: PW] = PW'(r*16 + c);
    pulse_start(1'b0, 11'h100);
    wait_done("basic_timeout");
    check("basic_count", BW'(acc_d.size()), BW'(8));
    check("basic_lane_r3c5", BW'(acc_d[3][5*PW +: PW]), BW'(16'h0035));
    check("basic_addr0", BW'(acc_a[0]), BW'(11'h100));
    check("basic_addr7", BW'(acc_a[7]), BW'(11'h107));
    check("basic_first_beat_lat", BW'(acc_c[0] - start_cyc), BW'(1));
    check("basic_done_lat", BW'(done_cyc - start_cyc), BW'(9));

    // ReLU on and off.
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) in_sta[(r*C + c)*PW +: PW] = (c % 2) ? 16'hFFFF : 16'h0005;
    pulse_start(1'b1, 11'h000);
    wait_done("relu_timeout");
    check("relu_lane0", BW'(acc_d[2][15:0]), BW'(16'h0005));
    check("relu_lane1", BW'(acc_d[2][31:16]), BW'(16'h0000));
    pulse_start(1'b0, 11'h000);
    wait_done("norelu_timeout");
    check("norelu_lane1", BW'(acc_d[0][31:16]), BW'(16'hFFFF));

    // Randomized backpressure.
    rdy_mode = 1;
    for (int k = 0; k < 3; k++) begin
      rand_sta();
      pulse_start(1'($urandom_range(0, 1)), AW'($urandom));
      wait_done("bp_timeout");
      check("bp_count", BW'(acc_d.size()), BW'(8));
      check("bp_done_after_last", BW'(done_cyc - acc_c[7]), BW'(1));
    end

    // Snapshot isolation with a dropped start at beat 3.
    rand_sta();
    pulse_start(1'b0, 11'h055);
    fired = 0;
    n = 0;
    while (done_cnt == 0 && n < 200) begin
      rand_sta();
      if (acc_c.size() == 3 && !fired) begin
        start = 1'b1;
        fired = 1;
      end else begin
        start = 1'b0;
      end
      step();
      n++;
    end
    start = 1'b0;
    check("iso_timeout", BW'(n < 200), BW'(1));
    step();
    check("iso_count", BW'(acc_d.size()), BW'(8));
    check("iso_dropped", BW'(start_dropped), BW'(1));
    pulse_start(1'b1, 11'h200);
    wait_done("restart_timeout");
    check("restart_count", BW'(acc_d.size()), BW'(8));
    check("dropped_sticky", BW'(start_dropped), BW'(1));

    // Address wrap.
    rdy_mode = 0;
    pulse_start(1'b0, 11'h7FE);
    wait_done("wrap_timeout");
    check("wrap_addr1", BW'(acc_a[1]), BW'(11'h7FF));
    check("wrap_addr2", BW'(acc_a[2]), BW'(11'h000));
    check("wrap_addr7", BW'(acc_a[7]), BW'(11'h005));

    // Reset after the fourth accepted beat.
    rdy_mode = 1;
    rand_sta();
    pulse_start(1'b0, 11'h300);
    n = 0;
    while (acc_c.size() < 4 && n < 200) begin
      step();
      n++;
    end
    check("rst_wait_timeout", BW'(n < 200), BW'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_valid", BW'(o_valid), BW'(0));
    check("rst_busy", BW'(busy), BW'(0));
    check("rst_addr", BW'(o_addr), BW'(0));
    check("rst_dropped", BW'(start_dropped), BW'(0));
    repeat (12) step();
    check("rst_no_done", BW'(done_cnt), BW'(0));
    check("rst_no_beats", BW'(acc_d.size()), BW'(4));
    pulse_start(1'b0, 11'h010);
    wait_done("post_rst_timeout");
    check("post_rst_count", BW'(acc_d.size()), BW'(8));
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/os_psum_drain.md
Name: os_psum_drain

Overview:
- Downstream consumer of the corelet's output-stationary result bus (`out_sta`, row*col psums).
- On a start pulse it snapshots the whole stationary psum array into a local register bank.
- It then serializes the snapshot one PE row per transfer onto a ready/valid write port, with optional ReLU and an incrementing SRAM address.
- This frees the MAC array to start the next OS tile while the drain is in progress.

Parameters:
- row, 8, PE rows in the MAC array; equals the number of drain beats.
- col, 8, PE columns; psums per beat.
- psum_bw, 16, signed psum width.
- addr_bw, 11, output SRAM address width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to snapshot and drain
- relu_en  input  1  apply ReLU to drained data; sampled with start
- base_addr  input  addr_bw  SRAM address of first drained row; sampled with start
- in_sta  input  row*col*psum_bw  stationary psums; PE(r,c) at bits [(r*col+c)*psum_bw +: psum_bw]
- o_valid  output  1  beat available
- o_ready  input  1  downstream accepts beat
- o_data  output  col*psum_bw  row beat; column c at [c*psum_bw +: psum_bw]
- o_addr  output  addr_bw  SRAM address for current beat
- busy  output  1  high in DRAIN or DONE
- done  output  1  one-cycle pulse after last beat accepted
- start_dropped  output  1  sticky flag: start seen while busy

Behaviour:
- Reset is synchronous and active-high on clk. It forces the following:
  - state=IDLE, row_idx=0.
  - snapshot cleared to 0.
  - o_valid=0, o_data=0, o_addr=0.
  - busy=0, done=0, start_dropped=0.
- Reset asserted mid-drain aborts immediately: no further beats and no done pulse.
- FSM states: IDLE, DRAIN, DONE.
- IDLE:
  - If start=1 at edge t: capture all of in_sta into the snapshot, latch relu_en and base_addr, set row_idx=0, go to DRAIN.
  - o_valid=1 from cycle t+1.
- DRAIN:
  - o_valid=1.
  - o_data = snapshot row row_idx; if latched relu_en, each column lane with MSB=1 is replaced by 0, otherwise passed unchanged.
  - o_addr = latched base_addr + row_idx, modulo 2^addr_bw (wraps silently).
  - On o_valid & o_ready: if row_idx==row-1, go to DONE; else row_idx+1.
- DONE:
  - done=1 and o_valid=0 for exactly one cycle, then return to IDLE.
  - A start in this cycle counts as while-busy.
- Handshake rules:
  - While o_valid=1 and o_ready=0, o_data and o_addr hold stable.
  - Beats are never skipped or duplicated.
  - o_ready is ignored when o_valid=0.
- o_data/o_addr when o_valid=0 are don't-care; the implementation drives 0.
- Snapshot isolation: in_sta changes after the capture edge must not affect drained data.
- start while busy (DRAIN or DONE):
  - The start is ignored; the snapshot, relu_en and base_addr are not modified.
  - start_dropped is set and stays set until reset.
- Throughput: with o_ready held 1, a drain takes row beats in consecutive cycles, then 1 DONE cycle. Minimum start-to-start interval is row+2 cycles (start, row beats, DONE).
- All outputs are registered or derived from state/snapshot registers only; there is no combinational path from in_sta or start to outputs.

Test Plan:
- Basic drain: row=col=8, in_sta PE(r,c)=r*16+c, base_addr=0x100, relu_en=0, o_ready=1, start pulse at cycle 0.
  - Beats in cycles 1..8 with addr 0x100..0x107.
  - Beat r lane c = r*16+c.
  - done pulses at cycle 9.
- ReLU: PE(r,c) = -1 (0xFFFF) for odd c, +5 for even c, relu_en=1.
  - Every beat has lanes 0x0005 and 0x0000 alternating.
  - With relu_en=0 the odd lanes read 0xFFFF.
- Backpressure: o_ready pattern 1,0,0,1,0,1,... (randomized).
  - Exactly 8 accepted beats, in order, with correct addresses.
  - o_data/o_addr stable during stalls.
  - done occurs exactly 1 cycle after the 8th accept.
- Snapshot isolation and dropped start:
  - Change in_sta every cycle during the drain → drained data still equals the value at the start edge.
  - Pulse start at beat 3 → it is ignored and start_dropped=1 persists.
  - A subsequent start after done works normally.
- Address wrap: base_addr=0x7FE (addr_bw=11) → addresses 0x7FE, 0x7FF, 0x000 ... 0x005.
- Reset mid-drain: assert reset after beat 4 is accepted.
  - Next cycle all outputs are 0 and state is IDLE, with no done pulse.
  - A new start yields a full 8-beat drain.
